// File: rtl/iob_cache_write_buffer.sv
// iob_cache_write_buffer: FIFO of front-end write-through stores drained one at a time
// through a registered back-end write channel.
module iob_cache_write_buffer #(
    parameter int FE_ADDR_W = 24,
    parameter int FE_DATA_W = 32,
    parameter int DEPTH_W = 2,
    localparam int FE_NBYTES = FE_DATA_W / 8,
    localparam int FE_NBYTES_W = $clog2(FE_NBYTES)
) (
    input  logic                             clk_i,
    input  logic                             arst_n_i,
    input  logic                             cke_i,
    input  logic                             fe_valid_i,
    input  logic [FE_ADDR_W-1:FE_NBYTES_W]   fe_addr_i,
    input  logic [FE_DATA_W-1:0]             fe_wdata_i,
    input  logic [FE_NBYTES-1:0]             fe_wstrb_i,
    output logic                             fe_ready_o,
    output logic                             write_valid_o,
    output logic [FE_ADDR_W-1:FE_NBYTES_W]   write_addr_o,
    output logic [FE_DATA_W-1:0]             write_wdata_o,
    output logic [FE_NBYTES-1:0]             write_wstrb_o,
    input  logic                             write_ready_i,
    output logic                             empty_o,
    output logic                             full_o,
    output logic [DEPTH_W:0]                 level_o,
    output logic                             busy_o
);
    localparam int DEPTH = 2 ** DEPTH_W;
    localparam int PAYLOAD_W = (FE_ADDR_W - FE_NBYTES_W) + FE_DATA_W + FE_NBYTES;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                 state_q, state_d;
    logic [DEPTH_W:0]       wr_ptr_q, rd_ptr_q;
    logic [PAYLOAD_W-1:0]   mem_q [DEPTH];
    logic [PAYLOAD_W-1:0]   out_q;
    logic                   empty, full, push, pop_req, pop;

    assign empty = wr_ptr_q == rd_ptr_q;
    assign full  = (wr_ptr_q[DEPTH_W-1:0] == rd_ptr_q[DEPTH_W-1:0]) &
                   (wr_ptr_q[DEPTH_W] != rd_ptr_q[DEPTH_W]);
    assign push  = fe_valid_i & ~full & cke_i;
    assign pop   = pop_req & cke_i;

    always_comb begin
        state_d = state_q;
        pop_req = 1'b0;
        unique case (state_q)
            IDLE: begin
                pop_req = ~empty;
                state_d = empty ? IDLE : ISSUE;
            end
            ISSUE: begin
                // a completing transfer refills the output register in the same cycle
                pop_req = write_ready_i & ~empty;
                state_d = (write_ready_i & empty) ? IDLE : ISSUE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            out_q    <= '0;
        end else if (cke_i) begin
            state_q <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + (DEPTH_W+1)'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (DEPTH_W+1)'(1);
                out_q    <= mem_q[rd_ptr_q[DEPTH_W-1:0]];
            end
        end
    end

    // storage needs no reset: only entries behind wr_ptr are ever read
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[DEPTH_W-1:0]] <= {fe_addr_i, fe_wdata_i, fe_wstrb_i};
    end

    assign {write_addr_o, write_wdata_o, write_wstrb_o} = out_q;
    assign write_valid_o = state_q == ISSUE;
    assign fe_ready_o    = ~full;
    assign empty_o       = empty;
    assign full_o        = full;
    assign level_o       = wr_ptr_q - rd_ptr_q;
    assign busy_o        = write_valid_o | ~empty;
endmodule

// File: tb/tb_iob_cache_write_buffer.sv
// tb_iob_cache_write_buffer: scoreboard bench with an occupancy-level reference model.
module tb_iob_cache_write_buffer;
    localparam int FE_ADDR_W = 24;
    localparam int FE_DATA_W = 32;
    localparam int DEPTH_W = 2;
    localparam int NB = 4;
    localparam int AW = FE_ADDR_W - 2;
    localparam int PW = AW + FE_DATA_W + NB;
    localparam int DEPTH = 4;

    logic clk = 0, arst_n = 0, cke = 1, fe_valid = 0, write_ready = 0;
    logic [AW-1:0] fe_addr = '0;
    logic [FE_DATA_W-1:0] fe_wdata = '0;
    logic [NB-1:0] fe_wstrb = '0;
    logic fe_ready, write_valid, empty, full, busy;
    logic [AW-1:0] write_addr;
    logic [FE_DATA_W-1:0] write_wdata;
    logic [NB-1:0] write_wstrb;
    logic [DEPTH_W:0] level;

    int checks = 0, failures = 0, done_cnt = 0, base = 0;
    int m_level = 0;
    bit m_ov = 0;
    logic [PW-1:0] exp_q[$];
    logic [FE_DATA_W-1:0] last_data = '0;

    iob_cache_write_buffer #(.FE_ADDR_W(FE_ADDR_W), .FE_DATA_W(FE_DATA_W), .DEPTH_W(DEPTH_W)) dut (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
        .fe_valid_i(fe_valid), .fe_addr_i(fe_addr), .fe_wdata_i(fe_wdata), .fe_wstrb_i(fe_wstrb),
        .fe_ready_o(fe_ready), .write_valid_o(write_valid), .write_addr_o(write_addr),
        .write_wdata_o(write_wdata), .write_wstrb_o(write_wstrb), .write_ready_i(write_ready),
        .empty_o(empty), .full_o(full), .level_o(level), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(string n, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: storage occupancy plus "output register holds a write" flag;
    // accepted payloads go to the scoreboard in arrival order.
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m_level <= 0;
            m_ov <= 0;
            exp_q.delete();
        end else if (cke) begin
            automatic bit acc = fe_valid && (m_level < DEPTH);
            automatic bit take = (m_level > 0) && (!m_ov || write_ready);
            if (acc) exp_q.push_back({fe_addr, fe_wdata, fe_wstrb});
            m_level <= m_level + int'(acc) - int'(take);
            m_ov <= take || (m_ov && !write_ready);
        end
    end

    always @(negedge clk) begin
        if (arst_n) begin
            chk("write_valid", write_valid, m_ov);
            chk("level", level, m_level);
            chk("empty", empty, m_level == 0);
            chk("full", full, m_level == DEPTH);
            chk("fe_ready", fe_ready, m_level != DEPTH);
            chk("busy", busy, m_ov || m_level > 0);
            if (write_valid) begin
                if (exp_q.size() == 0) chk("spurious_write", 1, 0);
                else begin
                    chk("payload", {write_addr, write_wdata, write_wstrb}, exp_q[0]);
                    if (cke && write_ready) begin
                        void'(exp_q.pop_front());
                        done_cnt++;
                        last_data = write_wdata;
                    end
                end
            end
        end
    end

    task automatic push(input logic [AW-1:0] a, input logic [FE_DATA_W-1:0] d, input logic [NB-1:0] s);
        fe_valid = 1; fe_addr = a; fe_wdata = d; fe_wstrb = s;
        tick();
        fe_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        write_ready = 1;
        while (busy && n < 100) begin tick(); n++; end
        chk("drain_timeout", busy, 0);
        write_ready = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fe_ready", fe_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valid", write_valid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_payload", {write_addr, write_wdata, write_wstrb}, 0);
        arst_n = 1;
        tick();
        // single write
        push(AW'(24'h10 >> 2), 32'hDEADBEEF, 4'hF);
        chk("sw_busy_c1", busy, 1);
        chk("sw_valid_c1", write_valid, 0);
        tick();
        chk("sw_valid_c2", write_valid, 1);
        chk("sw_wdata_c2", write_wdata, 32'hDEADBEEF);
        chk("sw_addr_c2", write_addr, 4);
        write_ready = 1;
        tick();
        write_ready = 0;
        chk("sw_valid_c3", write_valid, 0);
        chk("sw_busy_c3", busy, 0);
        // fill and overflow
        for (int i = 1; i <= 5; i++) push(AW'(i), FE_DATA_W'(i), 4'hF);
        chk("fill_full", full, 1);
        chk("fill_level", level, 4);
        chk("fill_ready", fe_ready, 0);
        push(AW'(6), 6, 4'hF);
        base = done_cnt;
        drain();
        chk("fill_count", done_cnt - base, 5);
        chk("fill_last", last_data, 5);
        // back-to-back drain
        for (int i = 0; i < 4; i++) push(AW'(i), 32'h100 + i, 4'(i + 1));
        tick();
        base = done_cnt;
        write_ready = 1;
        repeat (4) tick();
        write_ready = 0;
        chk("b2b_count", done_cnt - base, 4);
        chk("b2b_empty", empty, 1);
        chk("b2b_busy", busy, 0);
        // wrap-around
        base = done_cnt;
        write_ready = 1;
        for (int i = 0; i < 10; i++) begin
            fe_valid = 1; fe_addr = AW'($urandom); fe_wdata = $urandom; fe_wstrb = 4'($urandom);
            tick();
            chk("wrap_level_le1", level > 1, 0);
        end
        fe_valid = 0;
        drain();
        chk("wrap_count", done_cnt - base, 10);
        // stall
        push(AW'(7), 32'hCAFE0001, 4'h3);
        tick();
        chk("stall_valid", write_valid, 1);
        cke = 0; write_ready = 1; base = done_cnt;
        repeat (3) tick();
        chk("stall_no_done", done_cnt - base, 0);
        chk("stall_hold_valid", write_valid, 1);
        chk("stall_hold_data", write_wdata, 32'hCAFE0001);
        cke = 1;
        tick();
        write_ready = 0;
        chk("stall_one_done", done_cnt - base, 1);
        tick();
        chk("stall_one_done_after", done_cnt - base, 1);
        chk("stall_idle", write_valid, 0);
        // reset mid-drain
        for (int i = 0; i < 4; i++) push(AW'(i + 20), 32'hBAD0 + i, 4'hF);
        tick();
        chk("rstm_valid_pre", write_valid, 1);
        chk("rstm_level_pre", level, 3);
        #2 arst_n = 0;
        #1;
        chk("rstm_valid_async", write_valid, 0);
        chk("rstm_level_async", level, 0);
        tick();
        arst_n = 1;
        chk("rstm_level", level, 0);
        chk("rstm_empty", empty, 1);
        chk("rstm_ready", fe_ready, 1);
        base = done_cnt;
        write_ready = 1;
        repeat (5) tick();
        write_ready = 0;
        chk("rstm_no_stale", done_cnt - base, 0);
        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            fe_valid = 1'($urandom_range(0, 1));
            fe_addr = AW'($urandom); fe_wdata = $urandom; fe_wstrb = 4'($urandom);
            write_ready = $urandom_range(0, 2) != 0;
            cke = $urandom_range(0, 7) != 0;
            tick();
        end
        fe_valid = 0; cke = 1;
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
